// File: rtl/program_loader.sv
// program_loader: assembles a byte stream into instruction words and writes them
// to instruction memory from address 0, holding the CPU for the whole load. Optional macro: CHECKSUM_EN.
module program_loader #(
    parameter int ADDR_W = 8,
    parameter int WORD_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [WORD_W-1:0] im_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int BYTES = WORD_W / 8;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEN   = 3'd1;
    localparam logic [2:0] S_BYTE  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
`ifdef CHECKSUM_EN
    localparam logic [2:0] S_CHK   = 3'd4;
`endif
    localparam logic [2:0] S_FIN   = 3'd5;

    logic [2:0]        state, state_nx;
    logic [7:0]        count, index, byte_cnt;
    logic [WORD_W-1:0] shreg, word_nx;
    logic              xfer, last_byte, last_word;

    assign xfer      = in_valid & in_ready;
    assign word_nx   = (shreg << 8) | WORD_W'(in_data);
    assign last_byte = (byte_cnt == 8'(BYTES - 1));
    // count 0 encodes 256 words; the 8-bit wrap of count-1 gives 255
    assign last_word = (index == count - 8'd1);
    assign cpu_hold  = busy;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_LEN;
            S_LEN:   if (xfer) state_nx = S_BYTE;
            S_BYTE:  if (xfer && last_byte) state_nx = S_WRITE;
            S_WRITE: begin
                if (!last_word)
                    state_nx = S_BYTE;
                else
`ifdef CHECKSUM_EN
                    state_nx = S_CHK;
`else
                    state_nx = S_FIN;
`endif
            end
`ifdef CHECKSUM_EN
            S_CHK:   if (xfer) state_nx = S_FIN;
`endif
            S_FIN:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Handshake and strobe outputs are registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            in_ready <= 1'b0;
            im_we    <= 1'b0;
            im_addr  <= '0;
            im_wdata <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            count    <= '0;
            index    <= '0;
            byte_cnt <= '0;
            shreg    <= '0;
        end else begin
            state    <= state_nx;
`ifdef CHECKSUM_EN
            in_ready <= (state_nx == S_LEN) || (state_nx == S_BYTE) || (state_nx == S_CHK);
`else
            in_ready <= (state_nx == S_LEN) || (state_nx == S_BYTE);
`endif
            im_we    <= (state_nx == S_WRITE);
            done     <= (state_nx == S_FIN);
            busy     <= (state_nx != S_IDLE) && (state_nx != S_FIN);
            case (state)
                S_LEN: begin
                    if (xfer) begin
                        count    <= in_data;
                        index    <= '0;
                        byte_cnt <= '0;
                    end
                end
                S_BYTE: begin
                    if (xfer) begin
                        shreg <= word_nx;
                        if (last_byte) begin
                            byte_cnt <= '0;
                            im_addr  <= index[ADDR_W-1:0];
                            im_wdata <= word_nx;
                        end else begin
                            byte_cnt <= byte_cnt + 8'd1;
                        end
                    end
                end
                S_WRITE: if (!last_word) index <= index + 8'd1;
                default: ;
            endcase
        end
    end

`ifdef CHECKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum <= '0;
            err  <= 1'b0;
        end else begin
            if (state == S_IDLE && start) err <= 1'b0;
            if (state == S_LEN && xfer)
                csum <= in_data;
            else if (state == S_BYTE && xfer)
                csum <= csum ^ in_data;
            if (state == S_CHK && xfer) err <= (csum != in_data);
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: table-driven loads plus reset-abort and 256-word sequences,
// with a write scoreboard. Honours CHECKSUM_EN when defined.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        im_we;
    logic [7:0]  im_addr;
    logic [15:0] im_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;

    int total = 0;
    int bad   = 0;
    int wr_cnt = 0;

    logic [23:0] exp_q[$];
    logic [15:0] words[256];

    typedef struct {
        int              n;
        logic [2:0][15:0] w;
        int              gap;
        bit              bad_cs;
    } vec_t;

    vec_t vecs[4];

    program_loader #(.ADDR_W(8), .WORD_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .im_we    (im_we),
        .im_addr  (im_addr),
        .im_wdata (im_wdata),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every write strobe pops and compares one expected {addr, data}
    always @(negedge clk) begin
        if (im_we) begin
            logic [23:0] e;
            wr_cnt++;
            chk("ready_low_in_write", {31'd0, in_ready}, 32'd0);
            chk("hold_in_write", {31'd0, cpu_hold}, 32'd1);
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("im_addr", {24'd0, im_addr}, {24'd0, e[23:16]});
                chk("im_wdata", {16'd0, im_wdata}, {16'd0, e[15:0]});
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int g;
        int t;
        g = (gap > 0) ? int'($urandom_range(gap, 0)) : 0;
        for (int i = 0; i < g; i++) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic run_load(input int n, input int gap, input bit bad_cs, input bit exp_err);
        logic [7:0] cs;
        int t;
        for (int k = 0; k < n; k++) exp_q.push_back({8'(k), words[k]});
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("hold_after_start", {31'd0, cpu_hold}, 32'd1);
        chk("err_cleared_by_start", {31'd0, err}, 32'd0);
        cs = 8'(n);
        send_byte(8'(n), gap);
        for (int k = 0; k < n; k++) begin
            cs = cs ^ words[k][15:8] ^ words[k][7:0];
            send_byte(words[k][15:8], gap);
            send_byte(words[k][7:0], gap);
        end
`ifdef CHECKSUM_EN
        send_byte(bad_cs ? (cs ^ 8'h01) : cs, gap);
`else
        if (bad_cs) cs = ~cs;
`endif
        t = 0;
        while (!done && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
        chk("busy_low_at_done", {31'd0, busy}, 32'd0);
        chk("hold_low_at_done", {31'd0, cpu_hold}, 32'd0);
        chk("err_at_done", {31'd0, err}, {31'd0, exp_err});
        chk("all_writes_seen", exp_q.size(), 32'd0);
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("err_sticky", {31'd0, err}, {31'd0, exp_err});
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int wr_before;
        bit ee;
        vecs[0] = '{2, {16'h0000, 16'hABCD, 16'h1234}, 0, 1'b0};
        vecs[1] = '{2, {16'h0000, 16'hABCD, 16'h1234}, 3, 1'b1};
        vecs[2] = '{1, {16'h0000, 16'h0000, 16'hFFFF}, 1, 1'b0};
        vecs[3] = '{3, {16'h00FF, 16'h8001, 16'h0000}, 2, 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_im_we", {31'd0, im_we}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_im_addr", {24'd0, im_addr}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < vecs[i].n; k++) words[k] = vecs[i].w[k];
`ifdef CHECKSUM_EN
            ee = vecs[i].bad_cs;
`else
            ee = 1'b0;
`endif
            run_load(vecs[i].n, vecs[i].gap, vecs[i].bad_cs, ee);
            repeat (2) @(negedge clk);
        end

        // Reset in the middle of a word: nothing written, outputs clear immediately
        wr_before = wr_cnt;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_byte(8'h02, 0);
        send_byte(8'h12, 0);
        chk("mid_busy", {31'd0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_in_ready", {31'd0, in_ready}, 32'd0);
        chk("async_busy", {31'd0, busy}, 32'd0);
        chk("async_hold", {31'd0, cpu_hold}, 32'd0);
        chk("async_im_we", {31'd0, im_we}, 32'd0);
        chk("async_wdata", {16'd0, im_wdata}, 32'd0);
        chk("async_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_no_write", wr_cnt - wr_before, 32'd0);
        chk("abort_idle_ready", {31'd0, in_ready}, 32'd0);

        words[0] = 16'h1234;
        words[1] = 16'hABCD;
        run_load(2, 0, 1'b0, 1'b0);

        // Count byte 0 means 256 words, addresses 00..FF
        wr_before = wr_cnt;
        for (int k = 0; k < 256; k++) words[k] = {8'(k), ~8'(k)};
        run_load(256, 0, 1'b0, 1'b0);
        chk("full_256_writes", wr_cnt - wr_before, 32'd256);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
